// File: rtl/snn_pixel_feeder_if.sv
// Pixel feeder port bundle: image load, core protocol and result handshake.
// Winner outputs exist only when SNN_FEEDER_WINNER_EN is defined.
interface snn_pixel_feeder_if #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int IMAGE_SIZE  = 784
);
  localparam int ADDR_W = $clog2(IMAGE_SIZE);

  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   wr_drop;
  logic                   img_go;
  logic                   busy;
  logic                   core_start;
  logic [DATA_WIDTH-1:0]  pixel_data;
  logic                   step_done;
  logic                   layer_done;
  logic [NUM_NEURONS-1:0] spikes_in;
  logic                   result_valid;
  logic                   result_ready;
  logic [NUM_NEURONS-1:0] spikes_q;
  logic                   overrun;
`ifdef SNN_FEEDER_WINNER_EN
  logic [$clog2(NUM_NEURONS)-1:0] winner_idx;
  logic                   winner_valid;
`endif

  modport master (
    input  wr_en, wr_addr, wr_data, img_go,
    input  step_done, layer_done, spikes_in, result_ready,
    output wr_drop, busy, core_start, pixel_data,
`ifdef SNN_FEEDER_WINNER_EN
    output winner_idx, winner_valid,
`endif
    output result_valid, spikes_q, overrun
  );

  modport slave (
    output wr_en, wr_addr, wr_data, img_go,
    output step_done, layer_done, spikes_in, result_ready,
    input  wr_drop, busy, core_start, pixel_data,
`ifdef SNN_FEEDER_WINNER_EN
    input  winner_idx, winner_valid,
`endif
    input  result_valid, spikes_q, overrun
  );
endinterface

// File: rtl/snn_pixel_feeder.sv
// Image buffer and pixel sequencer for the LIF layer core; captures spikes.
// Optional SNN_FEEDER_WINNER_EN adds a registered lowest-index winner.
module snn_pixel_feeder #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int IMAGE_SIZE  = 784
) (
  input logic clk,
  input logic rst,
  snn_pixel_feeder_if.master io
);
  localparam int ADDR_W = $clog2(IMAGE_SIZE);
  localparam logic [ADDR_W:0] SIZE_X = (ADDR_W+1)'(IMAGE_SIZE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMAGE_SIZE - 1);

  typedef enum logic [1:0] {IDLE, START, FEED, RESULT} state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0]  mem [IMAGE_SIZE];
  logic [ADDR_W-1:0]      idx;
  logic [ADDR_W-1:0]      nidx;
  logic [DATA_WIDTH-1:0]  pix;
  logic [NUM_NEURONS-1:0] spk;
  logic                   drop;
  logic                   ovr;
  logic                   wr_ok;
  logic                   go;
  logic                   step;
  logic                   cap;

  assign wr_ok = io.wr_en && (state == IDLE)
              && ({1'b0, io.wr_addr} < SIZE_X);
  assign go    = (state == IDLE) && io.img_go;
  assign cap   = (state == FEED) && io.layer_done;
  // layer_done has priority over a coincident step_done
  assign step  = (state == FEED) && io.step_done
              && !io.layer_done;
  assign nidx  = idx + 1'b1;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (io.img_go) state_nx = START;
      START:  state_nx = FEED;
      FEED:   if (io.layer_done) state_nx = RESULT;
      RESULT: if (io.result_ready) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Buffer is never cleared; a write beside img_go lands after pixel 0 is read
  always_ff @(posedge clk) begin
    if (wr_ok) mem[io.wr_addr] <= io.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      pix  <= '0;
      spk  <= '0;
      ovr  <= 1'b0;
      drop <= 1'b0;
    end else begin
      drop <= io.wr_en && !wr_ok;
      if (go) begin
        idx <= '0;
        pix <= mem[0];
        ovr <= 1'b0;
      end else if (step) begin
        if (idx == LAST) begin
          ovr <= 1'b1;
        end else begin
          idx <= nidx;
          pix <= mem[nidx];
        end
      end
      if (cap) spk <= io.spikes_in;
    end
  end

`ifdef SNN_FEEDER_WINNER_EN
  localparam int WIN_W = $clog2(NUM_NEURONS);

  logic [WIN_W-1:0] win_nx;
  logic [WIN_W-1:0] win_q;
  logic             winv_q;

  always_comb begin
    win_nx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--)
      if (io.spikes_in[i]) win_nx = WIN_W'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q  <= '0;
      winv_q <= 1'b0;
    end else if (cap) begin
      win_q  <= win_nx;
      winv_q <= |io.spikes_in;
    end
  end

  assign io.winner_idx   = win_q;
  assign io.winner_valid = winv_q;
`endif

  assign io.wr_drop      = drop;
  assign io.busy         = (state != IDLE);
  assign io.core_start   = (state == START);
  assign io.pixel_data   = pix;
  assign io.result_valid = (state == RESULT);
  assign io.spikes_q     = spk;
  assign io.overrun      = ovr;
endmodule
